// File: rtl/qed_dup_sequencer_if.sv
// ---------------------------------------------------------------------------
// qed_dup_sequencer_if
//
// Bundles the control and status signals exchanged between the QED
// duplicate sequencer and its surroundings (fetch stage, QED i-cache,
// instruction mux, register-file checker).
//
// Signals
//   qed_enable      start or continue QED rounds
//   qed_switch_req  request an early switch to duplicate replay
//   IF_stall        fetch stall, the same signal the cache sees
//   qic_vld         cache vld_out: insert when exec_dup=0, delete when 1
//   exec_dup        duplicate-mode select for cache and mux
//   orig_count      originals captured in the current round
//   dup_count       duplicates replayed in the current round
//   check_valid     one-cycle pulse, register-file comparison is legal
//   busy            sequencer is in any state other than IDLE
//   protocol_err    sticky flag for qic_vld seen where it must not be
//
// Modports
//   slave   the sequencer itself (consumes the requests, drives status)
//   master  whatever drives the requests and observes the status
//
// Handshake: there is no ready/backpressure on this bus. qic_vld is a
// single-cycle qualifier; every cycle it is high counts as exactly one
// cache event, sampled on the rising clock edge. qed_switch_req is a level
// that must be held until the switch is taken (exec_dup rises).
// ---------------------------------------------------------------------------
interface qed_dup_sequencer_if #(
    parameter int CNT_W = 5
);
    logic             qed_enable;
    logic             qed_switch_req;
    logic             IF_stall;
    logic             qic_vld;
    logic             exec_dup;
    logic [CNT_W-1:0] orig_count;
    logic [CNT_W-1:0] dup_count;
    logic             check_valid;
    logic             busy;
    logic             protocol_err;

    modport slave (
        input  qed_enable,
        input  qed_switch_req,
        input  IF_stall,
        input  qic_vld,
        output exec_dup,
        output orig_count,
        output dup_count,
        output check_valid,
        output busy,
        output protocol_err
    );

    modport master (
        output qed_enable,
        output qed_switch_req,
        output IF_stall,
        output qic_vld,
        input  exec_dup,
        input  orig_count,
        input  dup_count,
        input  check_valid,
        input  busy,
        input  protocol_err
    );
endinterface

// File: rtl/qed_dup_sequencer.sv
// ---------------------------------------------------------------------------
// qed_dup_sequencer
//
// Mode controller for the QED instruction cache. Each QED round runs
// through original-instruction capture (ORIG), duplicate replay (DUP) and
// a fixed pipeline drain (DRAIN), then raises check_valid for one cycle
// (CHECK). exec_dup selects duplicate mode in the cache and mux.
//
// Parameters
//   DEPTH         cache entries; usable capacity per round is DEPTH-1
//   CNT_W         instruction counter width, 2^CNT_W > DEPTH-1
//   DRAIN_CYCLES  cycles spent in DRAIN before CHECK, >= 1
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   bus        qed_dup_sequencer_if slave modport (requests in, status out)
//   dbg_state  current FSM state encoding (IDLE=0 ORIG=1 DUP=2 DRAIN=3
//              CHECK=4) for checkers and debug
// ---------------------------------------------------------------------------
module qed_dup_sequencer #(
    parameter int DEPTH        = 16,
    parameter int CNT_W        = 5,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    qed_dup_sequencer_if.slave     bus,
    output logic [2:0]             dbg_state
);

    localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [CNT_W-1:0] CAP      = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYCLES);
    localparam logic [DRN_W-1:0] DRN_ONE  = DRN_W'(1);
    localparam logic [DRN_W-1:0] DRN_ZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ORIG  = 3'd1,
        S_DUP   = 3'd2,
        S_DRAIN = 3'd3,
        S_CHECK = 3'd4
    } state_t;

    state_t           state;
    state_t           state_d;

    logic [CNT_W-1:0] orig_q;
    logic [CNT_W-1:0] orig_d;
    logic [CNT_W-1:0] dup_q;
    logic [CNT_W-1:0] dup_d;
    logic [DRN_W-1:0] drn_q;
    logic [DRN_W-1:0] drn_d;

    logic [CNT_W-1:0] orig_next;
    logic [CNT_W-1:0] dup_next;
    logic             orig_full;
    logic             dup_done;
    logic             orig_inc;
    logic             dup_inc;
    logic             err_set;

    logic             exec_dup_q;
    logic             check_q;
    logic             busy_q;
    logic             err_q;

    // ------------------------------------------------------------------
    // Counter lookahead. A qic_vld that would push a counter past its
    // limit is a protocol error and is not counted, so the counters
    // saturate at DEPTH-1 (orig) and at orig_count (dup).
    // ------------------------------------------------------------------
    always_comb begin
        orig_full = (orig_q == CAP);
        dup_done  = (dup_q == orig_q);
        orig_inc  = bus.qic_vld && (state == S_ORIG) && !orig_full;
        dup_inc   = bus.qic_vld && (state == S_DUP) && !dup_done;
        orig_next = orig_q + {{(CNT_W-1){1'b0}}, orig_inc};
        dup_next  = dup_q + {{(CNT_W-1){1'b0}}, dup_inc};
    end

    // ------------------------------------------------------------------
    // protocol_err sources: cache activity in states where the cache must
    // be quiet, or beyond the capacity of the current phase.
    // ------------------------------------------------------------------
    always_comb begin
        err_set = 1'b0;
        if (bus.qic_vld) begin
            case (state)
                S_IDLE:  err_set = 1'b1;
                S_ORIG:  err_set = orig_full;
                S_DUP:   err_set = dup_done;
                S_DRAIN: err_set = 1'b1;
                S_CHECK: err_set = 1'b1;
                default: err_set = 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state and counter logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state;
        orig_d  = orig_q;
        dup_d   = dup_q;
        drn_d   = drn_q;

        case (state)
            S_IDLE: begin
                orig_d = CNT_ZERO;
                dup_d  = CNT_ZERO;
                drn_d  = DRN_ZERO;
                if (bus.qed_enable) begin
                    state_d = S_ORIG;
                end
            end

            S_ORIG: begin
                orig_d = orig_next;
                // A switch only happens on an unstalled cycle so the cache
                // and mux change mode on an instruction boundary. A switch
                // request with nothing captured yet is ignored.
                if (!bus.IF_stall &&
                    ((orig_next == CAP) ||
                     (bus.qed_switch_req && (orig_next != CNT_ZERO)))) begin
                    state_d = S_DUP;
                end else if (!bus.qed_enable && (orig_q == CNT_ZERO) &&
                             !bus.qic_vld) begin
                    // Disabling is only honoured before the first capture.
                    state_d = S_IDLE;
                end
            end

            S_DUP: begin
                dup_d = dup_next;
                if (dup_next == orig_q) begin
                    state_d = S_DRAIN;
                    drn_d   = DRN_LOAD;
                end
            end

            S_DRAIN: begin
                // Fixed-length drain, deliberately blind to IF_stall.
                if (drn_q != DRN_ZERO) begin
                    drn_d = drn_q - DRN_ONE;
                end
                if (drn_q <= DRN_ONE) begin
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                orig_d  = CNT_ZERO;
                dup_d   = CNT_ZERO;
                drn_d   = DRN_ZERO;
                state_d = bus.qed_enable ? S_ORIG : S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                orig_d  = CNT_ZERO;
                dup_d   = CNT_ZERO;
                drn_d   = DRN_ZERO;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and counter registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            orig_q <= CNT_ZERO;
            dup_q  <= CNT_ZERO;
            drn_q  <= DRN_ZERO;
        end else begin
            state  <= state_d;
            orig_q <= orig_d;
            dup_q  <= dup_d;
            drn_q  <= drn_d;
        end
    end

    // ------------------------------------------------------------------
    // Registered mode/status outputs, decoded from the next state so they
    // line up with the state register. exec_dup stays high through DRAIN
    // so the cache cannot accept new inserts while it is empty.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exec_dup_q <= 1'b0;
            check_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            exec_dup_q <= (state_d == S_DUP) || (state_d == S_DRAIN);
            check_q    <= (state_d == S_CHECK);
            busy_q     <= (state_d != S_IDLE);
            err_q      <= err_q || err_set;
        end
    end

    assign bus.exec_dup     = exec_dup_q;
    assign bus.orig_count   = orig_q;
    assign bus.dup_count    = dup_q;
    assign bus.check_valid  = check_q;
    assign bus.busy         = busy_q;
    assign bus.protocol_err = err_q;
    assign dbg_state        = state;

endmodule
